// File: rtl/edgetracing_accel_addr_gen.sv
// Byte-address generator around an external row*stride multiplier: addr = base + row*stride + col (EDGETRACING_ADDR_OVF_EN adds sticky overflow).
// Latency: MUL_LAT+1 cycles from request accept to out_valid.
// Backpressure: in_ready is a credit check over in-flight plus buffered entries; the multiplier never stalls.
module edgetracing_accel_addr_gen #(
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32,
    parameter int COL_W      = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [22:0]       in_row,
    input  logic [5:0]        in_stride,
    input  logic [COL_W-1:0]  in_col,
    input  logic [ADDR_W-1:0] in_base,
    input  logic              in_last,
    output logic              mul_ce,
    output logic [22:0]       mul_din0,
    output logic [5:0]        mul_din1,
    input  logic [28:0]       mul_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              ovf_flag
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = CNT_W + 1;

    typedef struct packed {
        logic [COL_W-1:0]  col;
        logic [ADDR_W-1:0] base;
        logic              last;
    } tag_t;

    logic [MUL_LAT-1:0] tag_vld;
    tag_t               tag_q [MUL_LAT];
    tag_t               tag_out;

    logic [ADDR_W:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   inflight;
    logic [CRED_W-1:0]  credits_used;
    logic [ADDR_W-1:0]  addr_sum;

    logic issue;
    logic retire;
    logic pop;

    assign mul_ce   = ap_rst_n;
    assign mul_din0 = in_row;
    assign mul_din1 = in_stride;

    // Credits come from registered state only, so a pop frees its slot one cycle later.
    assign credits_used = CRED_W'(inflight) + CRED_W'(fifo_count);
    assign in_ready     = ap_rst_n && (credits_used < CRED_W'(FIFO_DEPTH));
    assign out_valid    = ap_rst_n && (fifo_count != '0);

    assign issue   = in_valid && in_ready;
    assign tag_out = tag_q[MUL_LAT-1];
    assign retire  = tag_vld[MUL_LAT-1];
    assign pop     = out_valid && out_ready;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= issue;
            for (int i = 1; i < MUL_LAT; i++) tag_vld[i] <= tag_vld[i-1];
        end
    end

    always_ff @(posedge ap_clk) begin
        tag_q[0] <= {in_col, in_base, in_last};
        for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
    end

`ifdef EDGETRACING_ADDR_OVF_EN
    localparam int SUM_W = ADDR_W + 1;
    logic [ADDR_W:0] sum_full;
    logic            ovf_q;

    assign sum_full = {1'b0, tag_out.base} + SUM_W'(mul_dout) + SUM_W'(tag_out.col);
    assign addr_sum = sum_full[ADDR_W-1:0];
    assign ovf_flag = ovf_q;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ovf_q <= 1'b0;
        end else if (retire && sum_full[ADDR_W]) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign addr_sum = tag_out.base + ADDR_W'(mul_dout) + ADDR_W'(tag_out.col);
    assign ovf_flag = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (retire) fifo_mem[wr_ptr] <= {addr_sum, tag_out.last};
    end

    assign out_addr = fifo_mem[rd_ptr][ADDR_W:1];
    assign out_last = fifo_mem[rd_ptr][0];

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            if (retire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (retire && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !retire) fifo_count <= fifo_count - CNT_W'(1);
            if (issue && !retire)      inflight <= inflight + CNT_W'(1);
            else if (retire && !issue) inflight <= inflight - CNT_W'(1);
        end
    end

endmodule
